// File: rtl/qpu_exu_alu_arb_pkg.sv
// Shared constants for the EXU ALU arbiter: default datapath width and the
// source encoding used by the round-robin pointer.
package qpu_exu_alu_arb_pkg;

    localparam int QPU_XLEN = 32;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_BJP = 2'd1,
        SRC_QIU = 2'd2
    } src_e;

    // One-hot grant back to its encoded source; an empty grant reads as ALU.
    function automatic src_e src_encode(input logic [2:0] onehot);
        if (onehot[1]) return SRC_BJP;
        if (onehot[2]) return SRC_QIU;
        return SRC_ALU;
    endfunction

endpackage

// File: rtl/qpu_exu_alu_arb_rr.sv
// Three-way round-robin grant. The pointer remembers the last accepted source;
// the search starts at the source after it and wraps ALU -> BJP -> QIU.
module qpu_exu_alu_arb_rr
    import qpu_exu_alu_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       accept,
    output logic [2:0] grant
);

    src_e last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= SRC_QIU;
        end else if (accept) begin
            last_q <= src_encode(grant);
        end
    end

    always_comb begin
        grant = 3'b000;
        case (last_q)
            SRC_ALU: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            SRC_BJP: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/qpu_exu_alu_arb.sv
// Arbitrates ALU, branch-compare and timing-add requests onto one shared
// external datapath through an issue stage (S1) and a response stage (S2).
module qpu_exu_alu_arb
    import qpu_exu_alu_arb_pkg::*;
#(
    parameter int XLEN = QPU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            alu_i_valid,
    output logic            alu_i_ready,
    input  logic            alu_i_add,
    input  logic            alu_i_or,
    input  logic            alu_i_xor,
    input  logic            alu_i_and,
    input  logic [XLEN-1:0] alu_i_op1,
    input  logic [XLEN-1:0] alu_i_op2,

    input  logic            bjp_i_valid,
    output logic            bjp_i_ready,
    input  logic            bjp_i_cmp_eq,
    input  logic            bjp_i_cmp_ne,
    input  logic            bjp_i_cmp_lt,
    input  logic            bjp_i_cmp_gt,
    input  logic [XLEN-1:0] bjp_i_op1,
    input  logic [XLEN-1:0] bjp_i_op2,

    input  logic            qiu_i_valid,
    output logic            qiu_i_ready,
    input  logic [XLEN-1:0] qiu_i_op1,
    input  logic [XLEN-1:0] qiu_i_op2,

    output logic            alu_req_alu,
    output logic            bjp_req_alu,
    output logic            qiu_req_alu,
    output logic            alu_req_alu_add,
    output logic            alu_req_alu_or,
    output logic            alu_req_alu_xor,
    output logic            alu_req_alu_and,
    output logic            bjp_req_alu_cmp_eq,
    output logic            bjp_req_alu_cmp_ne,
    output logic            bjp_req_alu_cmp_lt,
    output logic            bjp_req_alu_cmp_gt,
    output logic [XLEN-1:0] alu_req_alu_op1,
    output logic [XLEN-1:0] alu_req_alu_op2,
    output logic [XLEN-1:0] bjp_req_alu_op1,
    output logic [XLEN-1:0] bjp_req_alu_op2,
    output logic [XLEN-1:0] qiu_req_alu_op1,
    output logic [XLEN-1:0] qiu_req_alu_op2,
    input  logic [XLEN-1:0] alu_req_alu_res,
    input  logic [XLEN-1:0] qiu_req_alu_res,
    input  logic            bjp_req_alu_cmp_res,

    output logic            alu_o_valid,
    input  logic            alu_o_ready,
    output logic [XLEN-1:0] alu_o_res,
    output logic            bjp_o_valid,
    input  logic            bjp_o_ready,
    output logic            bjp_o_cmp_res,
    output logic            qiu_o_valid,
    input  logic            qiu_o_ready,
    output logic [XLEN-1:0] qiu_o_res
);

    logic [2:0]      req_vld;
    logic [2:0]      o_ready_v;
    logic [2:0]      grant;
    logic [2:0]      in_ready;
    logic            accept;

    logic            s1_vld;
    logic [2:0]      s1_src;
    logic [3:0]      s1_op;
    logic [XLEN-1:0] s1_op1;
    logic [XLEN-1:0] s1_op2;
    logic [2:0]      s1_act;

    logic            s2_vld;
    logic [2:0]      s2_src;
    logic [XLEN-1:0] s2_res;
    logic [2:0]      o_act;

    logic            s2_fire;
    logic            s2_free;
    logic            s1_adv;
    logic            s1_free;

    logic [3:0]      req_op;
    logic [XLEN-1:0] req_op1;
    logic [XLEN-1:0] req_op2;
    logic [XLEN-1:0] dp_res;

    assign req_vld   = {qiu_i_valid, bjp_i_valid, alu_i_valid};
    assign o_ready_v = {qiu_o_ready, bjp_o_ready, alu_o_ready};

    assign s2_fire = s2_vld & |(s2_src & o_ready_v);
    assign s2_free = ~s2_vld | s2_fire;
    assign s1_adv  = s1_vld & s2_free;
    assign s1_free = ~s1_vld | s1_adv;

    // Ready is withheld during reset so nothing is accepted and then discarded.
    assign in_ready = grant & {3{s1_free & rst_n}};
    assign accept   = |(req_vld & in_ready);

    assign alu_i_ready = in_ready[0];
    assign bjp_i_ready = in_ready[1];
    assign qiu_i_ready = in_ready[2];

    qpu_exu_alu_arb_rr u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_vld),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        req_op  = 4'b0000;
        req_op1 = '0;
        req_op2 = '0;
        if (grant[0]) begin
            req_op  = {alu_i_and, alu_i_xor, alu_i_or, alu_i_add};
            req_op1 = alu_i_op1;
            req_op2 = alu_i_op2;
        end else if (grant[1]) begin
            req_op  = {bjp_i_cmp_gt, bjp_i_cmp_lt, bjp_i_cmp_ne, bjp_i_cmp_eq};
            req_op1 = bjp_i_op1;
            req_op2 = bjp_i_op2;
        end else if (grant[2]) begin
            req_op1 = qiu_i_op1;
            req_op2 = qiu_i_op2;
        end
    end

    // A new accept overwrites S1 directly; otherwise an advancing entry empties it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_src <= 3'b000;
            s1_op  <= 4'b0000;
            s1_op1 <= '0;
            s1_op2 <= '0;
        end else if (accept) begin
            s1_vld <= 1'b1;
            s1_src <= grant;
            s1_op  <= req_op;
            s1_op1 <= req_op1;
            s1_op2 <= req_op2;
        end else if (s1_adv) begin
            s1_vld <= 1'b0;
        end
    end

    assign s1_act = s1_src & {3{s1_vld & rst_n}};

    assign alu_req_alu        = s1_act[0];
    assign bjp_req_alu        = s1_act[1];
    assign qiu_req_alu        = s1_act[2];
    assign alu_req_alu_add    = s1_act[0] & s1_op[0];
    assign alu_req_alu_or     = s1_act[0] & s1_op[1];
    assign alu_req_alu_xor    = s1_act[0] & s1_op[2];
    assign alu_req_alu_and    = s1_act[0] & s1_op[3];
    assign bjp_req_alu_cmp_eq = s1_act[1] & s1_op[0];
    assign bjp_req_alu_cmp_ne = s1_act[1] & s1_op[1];
    assign bjp_req_alu_cmp_lt = s1_act[1] & s1_op[2];
    assign bjp_req_alu_cmp_gt = s1_act[1] & s1_op[3];
    assign alu_req_alu_op1    = s1_act[0] ? s1_op1 : '0;
    assign alu_req_alu_op2    = s1_act[0] ? s1_op2 : '0;
    assign bjp_req_alu_op1    = s1_act[1] ? s1_op1 : '0;
    assign bjp_req_alu_op2    = s1_act[1] ? s1_op2 : '0;
    assign qiu_req_alu_op1    = s1_act[2] ? s1_op1 : '0;
    assign qiu_req_alu_op2    = s1_act[2] ? s1_op2 : '0;

    always_comb begin
        dp_res = '0;
        if (s1_src[0]) begin
            dp_res = alu_req_alu_res;
        end else if (s1_src[1]) begin
            dp_res = {{(XLEN-1){1'b0}}, bjp_req_alu_cmp_res};
        end else if (s1_src[2]) begin
            dp_res = qiu_req_alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_src <= 3'b000;
            s2_res <= '0;
        end else if (s1_adv) begin
            s2_vld <= 1'b1;
            s2_src <= s1_src;
            s2_res <= dp_res;
        end else if (s2_fire) begin
            s2_vld <= 1'b0;
        end
    end

    assign o_act = s2_src & {3{s2_vld & rst_n}};

    assign alu_o_valid   = o_act[0];
    assign bjp_o_valid   = o_act[1];
    assign qiu_o_valid   = o_act[2];
    assign alu_o_res     = s2_res;
    assign bjp_o_cmp_res = s2_res[0];
    assign qiu_o_res     = s2_res;

endmodule

// File: tb/tb_qpu_exu_alu_arb.sv
// Directed bench for qpu_exu_alu_arb with a behavioural datapath and an
// in-order scoreboard of expected responses.
module tb_qpu_exu_alu_arb;

    logic        clk;
    logic        rst_n;

    logic        alu_i_valid, alu_i_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_op1, alu_op2;
    logic        bjp_i_valid, bjp_i_ready;
    logic [3:0]  bjp_op;
    logic [31:0] bjp_op1, bjp_op2;
    logic        qiu_i_valid, qiu_i_ready;
    logic [31:0] qiu_op1, qiu_op2;

    logic        alu_req_alu, bjp_req_alu, qiu_req_alu;
    logic        alu_req_alu_add, alu_req_alu_or, alu_req_alu_xor, alu_req_alu_and;
    logic        bjp_req_alu_cmp_eq, bjp_req_alu_cmp_ne, bjp_req_alu_cmp_lt, bjp_req_alu_cmp_gt;
    logic [31:0] alu_req_alu_op1, alu_req_alu_op2;
    logic [31:0] bjp_req_alu_op1, bjp_req_alu_op2;
    logic [31:0] qiu_req_alu_op1, qiu_req_alu_op2;
    logic [31:0] alu_req_alu_res, qiu_req_alu_res;
    logic        bjp_req_alu_cmp_res;

    logic        alu_o_valid, alu_o_ready;
    logic [31:0] alu_o_res;
    logic        bjp_o_valid, bjp_o_ready;
    logic        bjp_o_cmp_res;
    logic        qiu_o_valid, qiu_o_ready;
    logic [31:0] qiu_o_res;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] res;
    } sb_t;
    sb_t sb[$];

    qpu_exu_alu_arb #(.XLEN(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .alu_i_valid         (alu_i_valid),
        .alu_i_ready         (alu_i_ready),
        .alu_i_add           (alu_op[0]),
        .alu_i_or            (alu_op[1]),
        .alu_i_xor           (alu_op[2]),
        .alu_i_and           (alu_op[3]),
        .alu_i_op1           (alu_op1),
        .alu_i_op2           (alu_op2),
        .bjp_i_valid         (bjp_i_valid),
        .bjp_i_ready         (bjp_i_ready),
        .bjp_i_cmp_eq        (bjp_op[0]),
        .bjp_i_cmp_ne        (bjp_op[1]),
        .bjp_i_cmp_lt        (bjp_op[2]),
        .bjp_i_cmp_gt        (bjp_op[3]),
        .bjp_i_op1           (bjp_op1),
        .bjp_i_op2           (bjp_op2),
        .qiu_i_valid         (qiu_i_valid),
        .qiu_i_ready         (qiu_i_ready),
        .qiu_i_op1           (qiu_op1),
        .qiu_i_op2           (qiu_op2),
        .alu_req_alu         (alu_req_alu),
        .bjp_req_alu         (bjp_req_alu),
        .qiu_req_alu         (qiu_req_alu),
        .alu_req_alu_add     (alu_req_alu_add),
        .alu_req_alu_or      (alu_req_alu_or),
        .alu_req_alu_xor     (alu_req_alu_xor),
        .alu_req_alu_and     (alu_req_alu_and),
        .bjp_req_alu_cmp_eq  (bjp_req_alu_cmp_eq),
        .bjp_req_alu_cmp_ne  (bjp_req_alu_cmp_ne),
        .bjp_req_alu_cmp_lt  (bjp_req_alu_cmp_lt),
        .bjp_req_alu_cmp_gt  (bjp_req_alu_cmp_gt),
        .alu_req_alu_op1     (alu_req_alu_op1),
        .alu_req_alu_op2     (alu_req_alu_op2),
        .bjp_req_alu_op1     (bjp_req_alu_op1),
        .bjp_req_alu_op2     (bjp_req_alu_op2),
        .qiu_req_alu_op1     (qiu_req_alu_op1),
        .qiu_req_alu_op2     (qiu_req_alu_op2),
        .alu_req_alu_res     (alu_req_alu_res),
        .qiu_req_alu_res     (qiu_req_alu_res),
        .bjp_req_alu_cmp_res (bjp_req_alu_cmp_res),
        .alu_o_valid         (alu_o_valid),
        .alu_o_ready         (alu_o_ready),
        .alu_o_res           (alu_o_res),
        .bjp_o_valid         (bjp_o_valid),
        .bjp_o_ready         (bjp_o_ready),
        .bjp_o_cmp_res       (bjp_o_cmp_res),
        .qiu_o_valid         (qiu_o_valid),
        .qiu_o_ready         (qiu_o_ready),
        .qiu_o_res           (qiu_o_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[0]) return a + b;
        if (op[1]) return a | b;
        if (op[2]) return a ^ b;
        if (op[3]) return a & b;
        return 32'd0;
    endfunction

    function automatic logic bjp_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[0]) return a == b;
        if (op[1]) return a != b;
        if (op[2]) return $signed(a) < $signed(b);
        if (op[3]) return $signed(a) > $signed(b);
        return 1'b0;
    endfunction

    // External shared datapath, driven only by what the arbiter presents.
    always_comb begin
        alu_req_alu_res = alu_model({alu_req_alu_and, alu_req_alu_xor, alu_req_alu_or, alu_req_alu_add},
                                    alu_req_alu_op1, alu_req_alu_op2);
        bjp_req_alu_cmp_res = bjp_model({bjp_req_alu_cmp_gt, bjp_req_alu_cmp_lt, bjp_req_alu_cmp_ne, bjp_req_alu_cmp_eq},
                                        bjp_req_alu_op1, bjp_req_alu_op2);
        qiu_req_alu_res = qiu_req_alu_op1 + qiu_req_alu_op2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic src_ready(input int src);
        case (src)
            0:       return alu_i_ready;
            1:       return bjp_i_ready;
            default: return qiu_i_ready;
        endcase
    endfunction

    // Present one request on a source, hold it until accepted, then drop valid.
    task automatic applyStimulus(input int src, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic got;
        got = 1'b0;
        case (src)
            0:       begin alu_op = op; alu_op1 = a; alu_op2 = b; alu_i_valid = 1'b1; end
            1:       begin bjp_op = op; bjp_op1 = a; bjp_op2 = b; bjp_i_valid = 1'b1; end
            default: begin qiu_op1 = a; qiu_op2 = b; qiu_i_valid = 1'b1; end
        endcase
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = src_ready(src);
        end
        checkOutput("accept_wait", 32'(got), 32'd1);
        if (got) @(posedge clk);
        #1;
        alu_i_valid = 1'b0;
        bjp_i_valid = 1'b0;
        qiu_i_valid = 1'b0;
    endtask

    task automatic drainScoreboard();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on input handshakes, pop on output handshakes (pop first,
    // since a response always belongs to an older request).
    logic [1:0]  mon_src;
    logic [31:0] mon_res;
    logic        mon_rdy;
    sb_t         mon_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (alu_o_valid || bjp_o_valid || qiu_o_valid) begin
                checkOutput("o_valid_onehot", 32'(int'(alu_o_valid) + int'(bjp_o_valid) + int'(qiu_o_valid)), 32'd1);
                if (alu_o_valid) begin
                    mon_src = 2'd0; mon_res = alu_o_res; mon_rdy = alu_o_ready;
                end else if (bjp_o_valid) begin
                    mon_src = 2'd1; mon_res = {31'd0, bjp_o_cmp_res}; mon_rdy = bjp_o_ready;
                end else begin
                    mon_src = 2'd2; mon_res = qiu_o_res; mon_rdy = qiu_o_ready;
                end
                if (mon_rdy) begin
                    if (sb.size() == 0) begin
                        checkOutput("sb_unexpected_resp", 32'(mon_src), 32'd3);
                    end else begin
                        mon_exp = sb.pop_front();
                        checkOutput("sb_src", 32'(mon_src), 32'(mon_exp.src));
                        checkOutput("sb_res", mon_res, mon_exp.res);
                    end
                end
            end
            if (alu_i_valid && alu_i_ready) sb.push_back('{2'd0, alu_model(alu_op, alu_op1, alu_op2)});
            if (bjp_i_valid && bjp_i_ready) sb.push_back('{2'd1, {31'd0, bjp_model(bjp_op, bjp_op1, bjp_op2)}});
            if (qiu_i_valid && qiu_i_ready) sb.push_back('{2'd2, qiu_op1 + qiu_op2});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] exp_v;
        rst_n = 1'b0;
        alu_i_valid = 1'b0; alu_op = 4'd0; alu_op1 = '0; alu_op2 = '0;
        bjp_i_valid = 1'b0; bjp_op = 4'd0; bjp_op1 = '0; bjp_op2 = '0;
        qiu_i_valid = 1'b0; qiu_op1 = '0; qiu_op2 = '0;
        alu_o_ready = 1'b1; bjp_o_ready = 1'b1; qiu_o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("rst_o_valid", 32'({qiu_o_valid, bjp_o_valid, alu_o_valid}), 32'd0);
        checkOutput("rst_dp_sel", 32'({qiu_req_alu, bjp_req_alu, alu_req_alu}), 32'd0);
        checkOutput("rst_dp_op1", alu_req_alu_op1 | bjp_req_alu_op1 | qiu_req_alu_op1, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] ALU add latency");
        alu_op = 4'b0001; alu_op1 = 32'd5; alu_op2 = 32'd7; alu_i_valid = 1'b1;
        @(negedge clk);
        checkOutput("add_i_ready", 32'(alu_i_ready), 32'd1);
        @(posedge clk);
        #1 alu_i_valid = 1'b0;
        @(negedge clk);
        checkOutput("add_s1_sel", 32'({qiu_req_alu, bjp_req_alu, alu_req_alu}), 32'd1);
        checkOutput("add_s1_op", 32'({alu_req_alu_and, alu_req_alu_xor, alu_req_alu_or, alu_req_alu_add}), 32'd1);
        checkOutput("add_s1_op2", alu_req_alu_op2, 32'd7);
        checkOutput("add_n1_o_valid", 32'(alu_o_valid), 32'd0);
        @(negedge clk);
        checkOutput("add_n2_o_valid", 32'(alu_o_valid), 32'd1);
        checkOutput("add_n2_o_res", alu_o_res, 32'd12);
        @(posedge clk);
        #1;

        $display("[TB] compares and logic ops");
        applyStimulus(1, 4'b0100, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(1, 4'b1000, 32'd3, 32'd2);
        applyStimulus(1, 4'b0001, 32'd4, 32'd5);
        applyStimulus(1, 4'b0010, 32'd9, 32'd9);
        applyStimulus(0, 4'b0010, 32'hF0F0_0000, 32'h0000_0F0F);
        applyStimulus(0, 4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F);
        applyStimulus(0, 4'b1000, 32'hDEAD_BEEF, 32'h0000_FFFF);
        applyStimulus(0, 4'b0000, 32'hA5, 32'hA5);
        applyStimulus(2, 4'b0000, 32'd1, 32'd2);
        drainScoreboard();

        $display("[TB] full-rate round robin");
        alu_op = 4'b0001; alu_op1 = 32'd100; alu_op2 = 32'd1; alu_i_valid = 1'b1;
        bjp_op = 4'b0001; bjp_op1 = 32'd7;   bjp_op2 = 32'd7; bjp_i_valid = 1'b1;
        qiu_op1 = 32'd3; qiu_op2 = 32'd4; qiu_i_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_v = 3'b001 << (k % 3);
            checkOutput("rr_ready", 32'({qiu_i_ready, bjp_i_ready, alu_i_ready}), 32'(exp_v));
            if (k >= 2) begin
                exp_v = 3'b001 << ((k - 2) % 3);
                checkOutput("rr_o_valid", 32'({qiu_o_valid, bjp_o_valid, alu_o_valid}), 32'(exp_v));
            end
            @(posedge clk);
            #1;
            alu_op1 = alu_op1 + 32'd1;
            bjp_op1 = bjp_op1 + 32'd1;
            qiu_op1 = qiu_op1 + 32'd1;
        end
        alu_i_valid = 1'b0; bjp_i_valid = 1'b0; qiu_i_valid = 1'b0;
        drainScoreboard();

        $display("[TB] backpressure on QIU response");
        qiu_o_ready = 1'b0;
        applyStimulus(2, 4'b0000, 32'd10, 32'd20);
        alu_op = 4'b0001; alu_op1 = 32'd1; alu_op2 = 32'd1; alu_i_valid = 1'b1;
        bjp_op = 4'b0100; bjp_op1 = 32'd0; bjp_op2 = 32'd0; bjp_i_valid = 1'b1;
        @(negedge clk);
        checkOutput("bp_absorb_one", 32'(alu_i_ready), 32'd1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_qiu_valid", 32'(qiu_o_valid), 32'd1);
            checkOutput("bp_qiu_res", qiu_o_res, 32'd30);
            checkOutput("bp_i_ready", 32'({qiu_i_ready, bjp_i_ready, alu_i_ready}), 32'd0);
            @(posedge clk);
            #1;
        end
        alu_i_valid = 1'b0; bjp_i_valid = 1'b0;
        qiu_o_ready = 1'b1;
        drainScoreboard();

        $display("[TB] reset with both stages full");
        qiu_o_ready = 1'b0;
        applyStimulus(2, 4'b0000, 32'd10, 32'd1);
        applyStimulus(0, 4'b0100, 32'hF0, 32'h0F);
        rst_n = 1'b0;
        alu_op = 4'b0001; alu_op1 = 32'd2; alu_op2 = 32'd3; alu_i_valid = 1'b1;
        bjp_op = 4'b0001; bjp_i_valid = 1'b1;
        qiu_i_valid = 1'b1;
        @(negedge clk);
        checkOutput("inrst_o_valid", 32'({qiu_o_valid, bjp_o_valid, alu_o_valid}), 32'd0);
        checkOutput("inrst_i_ready", 32'({qiu_i_ready, bjp_i_ready, alu_i_ready}), 32'd0);
        checkOutput("inrst_dp_sel", 32'({qiu_req_alu, bjp_req_alu, alu_req_alu}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qiu_o_ready = 1'b1;
        @(negedge clk);
        checkOutput("postrst_o_valid", 32'({qiu_o_valid, bjp_o_valid, alu_o_valid}), 32'd0);
        checkOutput("postrst_dp_sel", 32'({qiu_req_alu, bjp_req_alu, alu_req_alu}), 32'd0);
        checkOutput("postrst_grant", 32'({qiu_i_ready, bjp_i_ready, alu_i_ready}), 32'd1);
        @(posedge clk);
        #1;
        alu_i_valid = 1'b0; bjp_i_valid = 1'b0; qiu_i_valid = 1'b0;
        drainScoreboard();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qpu_exu_alu_arb.md
QPU_EXU_ALU_ARB -- requirements
Module: QPU_exu_alu_arb

Interface
REQ-001 Parameter XLEN, default `QPU_XLEN (32), operand/result width.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 alu_i_valid/alu_i_ready  in/out  1/1  ALU-class request handshake.
REQ-006 alu_i_add, alu_i_or, alu_i_xor, alu_i_and  in  1 each  ALU op select, one-hot.
REQ-007 alu_i_op1, alu_i_op2  in  XLEN each  ALU operands.
REQ-008 bjp_i_valid/bjp_i_ready  in/out  1/1  branch-compare request handshake.
REQ-009 bjp_i_cmp_eq, _ne, _lt, _gt  in  1 each  compare select, one-hot; bjp_i_op1/op2 in XLEN.
REQ-010 qiu_i_valid/qiu_i_ready  in/out  1/1; qiu_i_op1/op2 in XLEN  timing-add request.
REQ-011 alu_req_alu, bjp_req_alu, qiu_req_alu  out  1 each  datapath source select, one-hot or all zero.
REQ-012 alu_req_alu_add/or/xor/and, bjp_req_alu_cmp_eq/ne/lt/gt, *_req_alu_op1/op2  out  datapath op and operand drive.
REQ-013 alu_req_alu_res, qiu_req_alu_res  in  XLEN; bjp_req_alu_cmp_res  in  1  datapath results.
REQ-014 alu_o_valid/alu_o_ready, alu_o_res  out/in/out  1/1/XLEN  ALU response.
REQ-015 bjp_o_valid/bjp_o_ready, bjp_o_cmp_res  out/in/out  1/1/1  compare response.
REQ-016 qiu_o_valid/qiu_o_ready, qiu_o_res  out/in/out  1/1/XLEN  timing-add response.

Function
REQ-017 Two stages: S1 issue register (source one-hot, op bits, op1, op2, s1_vld); S2 response register (source, result, s2_vld).
REQ-018 S1 contents drive the datapath ports combinationally; only the source port of the S1 entry is driven; all datapath outputs are 0 when s1_vld=0.
REQ-019 Transfer on a port occurs when valid & ready are both 1 at a rising edge.
REQ-020 Latency: request accepted at edge N gives response valid from edge N+2 when no stall.
REQ-021 s2_free = ~s2_vld | (matching *_o_ready); s1_adv = s1_vld & s2_free; s1_free = ~s1_vld | s1_adv.
REQ-022 At most one *_i_ready is 1, and only for the granted source when s1_free=1; ready does not depend on the same source's valid.
REQ-023 Grant: round-robin over valid requestors in order ALU->BJP->QIU, starting after the last accepted source; pointer updates only on an accepted transfer.
REQ-024 On s1_adv, S2 captures the datapath result for the S1 source (BJP: cmp_res zero-extended internally), and S1 clears unless a new request is accepted in the same cycle.
REQ-025 Simultaneous S2 drain and S1 advance in one cycle is allowed, giving full throughput of one op per cycle.
REQ-026 *_o_valid is 1 only for the S2 source; S2 holds result and valid stable until accepted.
REQ-027 Op bits are passed through unchecked; an ALU request with no op bit set returns 0.
REQ-028 Sustained backpressure: S1 and S2 both full, all *_i_ready=0; no request is lost or duplicated.

Reset
REQ-029 When rst_n=0 at an edge: s1_vld=0, s2_vld=0, RR pointer points so ALU has highest priority next, data registers cleared to 0.
REQ-030 During reset and the first cycle after, all *_o_valid=0 and all datapath drives are 0; in-flight requests are discarded.

Structure
REQ-031 XLEN default and source-encoding constants (SRC_ALU=0, SRC_BJP=1, SRC_QIU=2) live in QPU_defines.v.
REQ-032 One sub-module, QPU_exu_alu_rr_arb (3-way round-robin grant plus pointer); the datapath stays external.

Verification
REQ-033 ALU add, op1=5, op2=7, accepted at cycle N -> alu_o_valid and alu_o_res=12 at N+2.
REQ-034 BJP lt, op1=0xFFFFFFFF, op2=1 -> bjp_o_cmp_res=1; gt with op1=3, op2=2 -> 1.
REQ-035 All three valid every cycle, all o_ready=1 -> grants ALU,BJP,QIU,ALU... at one response per cycle.
REQ-036 qiu_o_ready=0 for 5 cycles after a QIU add of 10+20 -> qiu_o_res=30 held stable, at most one more request absorbed, then all i_ready=0.
REQ-037 rst_n=0 asserted with S1 and S2 full -> next cycle all valids 0, then the next grant goes to ALU.
REQ-038 ALU request with no op bit, op1=op2=0xA5 -> alu_o_res=0.
